// File: rtl/iprf_wr_arb.sv
// Integer PRF writeback arbiter: one holding entry per requester, round-robin packing onto the IPRF write ports.
// Optional starvation promotion under `IPRF_WR_ARB_STARVE_EN; duplicate-pdst check under `ASSERT.
package iprf_wr_arb_pkg;
    localparam int IPRF_NUM_WRITES = 2;
    localparam int PRF_PDST_W      = 7;
    localparam int PRF_DATA_W      = 32;

    typedef struct packed {
        logic [PRF_PDST_W-1:0] pdst;
        logic [PRF_DATA_W-1:0] data;
    } t_prf_wr_pkt;
endpackage

module iprf_wr_arb
    import iprf_wr_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  t_prf_wr_pkt                req_pkt [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [IPRF_NUM_WRITES-1:0] iprf_wr_en_ro0,
    output t_prf_wr_pkt                iprf_wr_pkt_ro0 [IPRF_NUM_WRITES]
);
    localparam int            NW        = IPRF_NUM_WRITES;
    localparam int            RR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [RR_W:0] NUM_REQ_X = (RR_W+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] hold_valid_q, hold_valid_d;
    t_prf_wr_pkt        hold_pkt_q [NUM_REQ];
    t_prf_wr_pkt        hold_pkt_d [NUM_REQ];
    logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NW-1:0]      wr_en_q, wr_en_d;
    t_prf_wr_pkt        wr_pkt_q [NW];
    t_prf_wr_pkt        wr_pkt_d [NW];

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] xfer;
    logic [NUM_REQ-1:0] promoted;
    logic [RR_W-1:0]    scan_idx [NUM_REQ];
    logic [NW-1:0]      port_hit;
    logic [RR_W-1:0]    port_src [NW];
    logic [RR_W-1:0]    last_idx;

    // Scan position k maps to requester (rr_ptr + k) mod NUM_REQ, wrapped explicitly.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
            logic [RR_W:0] sum;
            assign sum          = {1'b0, rr_ptr_q} + (RR_W+1)'(gi);
            assign scan_idx[gi] = (sum >= NUM_REQ_X) ? RR_W'(sum - NUM_REQ_X) : sum[RR_W-1:0];
        end
    endgenerate

`ifdef IPRF_WR_ARB_STARVE_EN
    logic [7:0] wait_cnt_q [NUM_REQ];
    logic [7:0] wait_cnt_d [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_promote
            assign promoted[gi] = hold_valid_q[gi] && (wait_cnt_q[gi] >= 8'(STARVE_LIMIT));
        end
    endgenerate

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            if (hold_valid_q[r] && !grant[r]) begin
                wait_cnt_d[r] = (wait_cnt_q[r] == 8'hFF) ? 8'hFF : wait_cnt_q[r] + 8'd1;
            end else begin
                wait_cnt_d[r] = 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REQ; r++) begin
            if (!reset_n) begin
                wait_cnt_q[r] <= 8'd0;
            end else begin
                wait_cnt_q[r] <= wait_cnt_d[r];
            end
        end
    end
`else
    assign promoted = '0;
`endif

    // Pass 0 takes promoted candidates, pass 1 the rest; both in rr order, packed onto ports as found.
    always_comb begin : arb_comb
        int n;
        n        = 0;
        grant    = '0;
        port_hit = '0;
        last_idx = rr_ptr_q;
        for (int w = 0; w < NW; w++) begin
            port_src[w] = '0;
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (hold_valid_q[scan_idx[k]] &&
                    (promoted[scan_idx[k]] == (pass == 0)) &&
                    (n < NW)) begin
                    grant[scan_idx[k]] = 1'b1;
                    for (int w = 0; w < NW; w++) begin
                        if (w == n) begin
                            port_hit[w] = 1'b1;
                            port_src[w] = scan_idx[k];
                        end
                    end
                    last_idx = scan_idx[k];
                    n        = n + 1;
                end
            end
        end
    end

    assign req_ready = ~hold_valid_q | grant;
    assign xfer      = req_valid & req_ready;

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            hold_valid_d[r] = xfer[r] | (hold_valid_q[r] & ~grant[r]);
            hold_pkt_d[r]   = xfer[r] ? req_pkt[r] : hold_pkt_q[r];
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|grant) begin
            rr_ptr_d = (last_idx == RR_W'(NUM_REQ - 1)) ? '0 : last_idx + RR_W'(1);
        end
    end

    always_comb begin
        wr_en_d = port_hit;
        for (int w = 0; w < NW; w++) begin
            wr_pkt_d[w] = port_hit[w] ? hold_pkt_q[port_src[w]] : wr_pkt_q[w];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_valid_q <= '0;
            rr_ptr_q     <= '0;
            wr_en_q      <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                hold_pkt_q[r] <= '0;
            end
            for (int w = 0; w < NW; w++) begin
                wr_pkt_q[w] <= '0;
            end
        end else begin
            hold_valid_q <= hold_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_en_q      <= wr_en_d;
            for (int r = 0; r < NUM_REQ; r++) begin
                hold_pkt_q[r] <= hold_pkt_d[r];
            end
            for (int w = 0; w < NW; w++) begin
                wr_pkt_q[w] <= wr_pkt_d[w];
            end
        end
    end

    assign iprf_wr_en_ro0 = wr_en_q;
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_out
            assign iprf_wr_pkt_ro0[gi] = wr_pkt_q[gi];
        end
    endgenerate

`ifdef ASSERT
    // Same pdst on two live ports means a producer issued a duplicate writeback.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int a = 0; a < NW; a++) begin
                for (int b = a + 1; b < NW; b++) begin
                    assert (!(wr_en_q[a] && wr_en_q[b] && (wr_pkt_q[a].pdst == wr_pkt_q[b].pdst)));
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_iprf_wr_arb.sv
// Directed bench for iprf_wr_arb with NUM_REQ=4 and two write ports.
// Starvation scenario runs only when IPRF_WR_ARB_STARVE_EN is defined.
`timescale 1ns/1ps
module tb_iprf_wr_arb;
    import iprf_wr_arb_pkg::*;

    localparam int NR = 4;
`ifdef IPRF_WR_ARB_STARVE_EN
    localparam int SL = 1;
`else
    localparam int SL = 8;
`endif

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [NR-1:0] req_valid;
    t_prf_wr_pkt   req_pkt [NR];
    logic [NR-1:0] req_ready;
    logic [1:0]    en;
    t_prf_wr_pkt   wpkt [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    iprf_wr_arb #(
        .NUM_REQ      (NR),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_pkt         (req_pkt),
        .req_ready       (req_ready),
        .iprf_wr_en_ro0  (en),
        .iprf_wr_pkt_ro0 (wpkt)
    );

    function automatic t_prf_wr_pkt mk(input logic [6:0] p, input logic [31:0] d);
        t_prf_wr_pkt x;
        x.pdst = p;
        x.data = d;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_ports(input string tag, input logic [1:0] ee,
                             input t_prf_wr_pkt e0, input t_prf_wr_pkt e1);
        chk({tag, "_en"}, 64'(en), 64'(ee));
        if (ee[0]) chk({tag, "_p0"}, 64'(wpkt[0]), 64'(e0));
        if (ee[1]) chk({tag, "_p1"}, 64'(wpkt[1]), 64'(e1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d rst_n=%b valid=%b ready=%b en=%b p0=%0h p1=%0h",
                 cyc, reset_n, req_valid, req_ready, en, wpkt[0], wpkt[1]);
    endtask

    task automatic clear_in();
        req_valid = '0;
        for (int r = 0; r < NR; r++) req_pkt[r] = '0;
    endtask

    initial begin
        int seq [NR];
        int s;

        // Reset then idle
        clear_in();
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_p0", 64'(wpkt[0]), 64'd0);
        chk("rst_p1", 64'(wpkt[1]), 64'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_en", 64'(en), 64'd0);
            chk("idle_rdy", 64'(req_ready), 64'hF);
        end

        // r2 streams pdst 5 for three cycles
        for (int i = 0; i < 6; i++) begin
            clear_in();
            if (i < 3) begin
                req_valid[2] = 1'b1;
                req_pkt[2]   = mk(7'd5, 32'hA0 + 32'(i));
            end
            chk("single_rdy2", 64'(req_ready[2]), 64'd1);
            tick();
            if (i >= 1 && i <= 3) chk_ports("single", 2'b01, mk(7'd5, 32'hA0 + 32'(i - 1)), '0);
            else chk("single_idle_en", 64'(en), 64'd0);
        end

        // rr_ptr is now 3: r3 and r0 wrap onto ports 0 and 1
        clear_in();
        req_valid[3] = 1'b1; req_pkt[3] = mk(7'd13, 32'hD3);
        req_valid[0] = 1'b1; req_pkt[0] = mk(7'd10, 32'hD0);
        chk("wrap_rdy0", 64'(req_ready), 64'hF);
        tick();
        chk("wrap_en0", 64'(en), 64'd0);
        clear_in();
        chk("wrap_rdy1", 64'(req_ready), 64'hF);
        req_valid[0] = 1'b1; req_pkt[0] = mk(7'd20, 32'hE0);
        req_valid[1] = 1'b1; req_pkt[1] = mk(7'd21, 32'hE1);
        req_valid[2] = 1'b1; req_pkt[2] = mk(7'd22, 32'hE2);
        tick();
        chk_ports("wrap_a", 2'b11, mk(7'd13, 32'hD3), mk(7'd10, 32'hD0));
        clear_in();
        chk("wrap_rdy2", 64'(req_ready), 64'hE);
        tick();
        chk_ports("wrap_b", 2'b11, mk(7'd21, 32'hE1), mk(7'd22, 32'hE2));
        chk("wrap_rdy3", 64'(req_ready), 64'hF);
        tick();
        chk_ports("wrap_c", 2'b01, mk(7'd20, 32'hE0), '0);
        tick();
        chk("wrap_idle_en", 64'(en), 64'd0);

        // Reset to rr_ptr 0, then all four continuously valid
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst2_en", 64'(en), 64'd0);
        for (int r = 0; r < NR; r++) seq[r] = 0;
        for (int c = 0; c < 7; c++) begin
            req_valid = 4'hF;
            for (int r = 0; r < NR; r++) req_pkt[r] = mk(7'(r * 8 + seq[r]), 32'(r * 100 + seq[r]));
            if (c == 0) chk("all_rdy", 64'(req_ready), 64'hF);
            else chk("all_rdy", 64'(req_ready), (c % 2 == 1) ? 64'h3 : 64'hC);
            for (int r = 0; r < NR; r++) if (req_ready[r]) seq[r]++;
            tick();
            if (c == 0) begin
                chk("all_en0", 64'(en), 64'd0);
            end else if (c % 2 == 1) begin
                s = (c - 1) / 2;
                chk_ports("all_a", 2'b11, mk(7'(s), 32'(s)), mk(7'(8 + s), 32'(100 + s)));
            end else begin
                s = (c - 2) / 2;
                chk_ports("all_b", 2'b11, mk(7'(16 + s), 32'(200 + s)), mk(7'(24 + s), 32'(300 + s)));
            end
        end

        // Reset while all four entries are held: nothing held may emerge
        clear_in();
        reset_n = 1'b0;
        tick();
        chk("midrst_en", 64'(en), 64'd0);
        chk("midrst_p0", 64'(wpkt[0]), 64'd0);
        reset_n = 1'b1;
        chk("midrst_rdy", 64'(req_ready), 64'hF);
        tick();
        chk("midrst_en1", 64'(en), 64'd0);
        tick();
        chk("midrst_en2", 64'(en), 64'd0);

`ifdef IPRF_WR_ARB_STARVE_EN
        // r3 loses once, then jumps ahead of r2 on port 0
        clear_in();
        req_valid = 4'b1011;
        req_pkt[0] = mk(7'd30, 32'h30);
        req_pkt[1] = mk(7'd31, 32'h31);
        req_pkt[3] = mk(7'd33, 32'h33);
        tick();
        chk("stv_en0", 64'(en), 64'd0);
        clear_in();
        chk("stv_rdy", 64'(req_ready), 64'h7);
        req_valid = 4'b0111;
        req_pkt[0] = mk(7'd40, 32'h40);
        req_pkt[1] = mk(7'd41, 32'h41);
        req_pkt[2] = mk(7'd42, 32'h42);
        tick();
        chk_ports("stv_a", 2'b11, mk(7'd30, 32'h30), mk(7'd31, 32'h31));
        clear_in();
        tick();
        chk_ports("stv_b", 2'b11, mk(7'd33, 32'h33), mk(7'd42, 32'h42));
        tick();
        chk_ports("stv_c", 2'b11, mk(7'd40, 32'h40), mk(7'd41, 32'h41));
        tick();
        chk("stv_idle_en", 64'(en), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/iprf_wr_arb.md
# iprf_wr_arb

Writeback arbiter for the integer physical register file. It shares the `IPRF_NUM_WRITES` IPRF write ports among `NUM_REQ` execution-unit result producers, using one holding entry per requester and round-robin grant. It drives the `iprf_wr_en_ro0` / `iprf_wr_pkt_ro0` bus that the PRF and the rename-stage pending-source watchers consume.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of writeback requesters; must be ≥ 1.
- `STARVE_LIMIT`, default 8: wait cycles before a requester is promoted. Used only with `IPRF_WR_ARB_STARVE_EN`; range 1..255.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset; synchronous, active-low.
- `req_valid`  in  1 [NUM_REQ]  requester r presents a result.
- `req_pkt`  in  t_prf_wr_pkt [NUM_REQ]  result packet (pdst, data).
- `req_ready`  out  1 [NUM_REQ]  requester r's holding entry can accept this cycle.
- `iprf_wr_en_ro0`  out  1 [IPRF_NUM_WRITES]  write port w is active.
- `iprf_wr_pkt_ro0`  out  t_prf_wr_pkt [IPRF_NUM_WRITES]  write port w packet.

## Operation
Holding entries:
- Each requester r has one entry: `hold_valid[r]` and `hold_pkt[r]`.
- `req_ready[r] = ~hold_valid[r] | grant[r]`.
- `grant` depends only on registered state, so there is no combinational path from `req_valid` to `req_ready`.
- A transfer occurs when `req_valid[r] & req_ready[r]`. The entry loads on the next edge.
- If the entry is granted and a transfer happens in the same cycle, the entry reloads and `hold_valid` stays 1. This gives 1 result per cycle per requester.
- If the entry is granted with no transfer, `hold_valid` clears.
- `req_pkt` is ignored when `req_valid` is 0.

Arbitration (combinational on held state):
- Candidates are all requesters with `hold_valid[r]`.
- Scan order is r = `rr_ptr`, `rr_ptr`+1, … modulo `NUM_REQ`.
- Grant the first `min(IPRF_NUM_WRITES, #candidates)` candidates in scan order.
- Granted requesters are packed onto ports in scan order: the first grant goes to port 0, the second to port 1, and so on. Unused ports are disabled.
- `rr_ptr` update on the edge:
  - With at least one grant: one past the last granted index, modulo `NUM_REQ`.
  - With no grant: unchanged.
- `rr_ptr` width is `$clog2(NUM_REQ)`, minimum 1 bit. The wrap from `NUM_REQ`-1 to 0 is explicit, so it also holds for non-power-of-2 `NUM_REQ`.
- If `NUM_REQ` ≤ `IPRF_NUM_WRITES`, every valid entry is granted every cycle.

Output stage:
- `iprf_wr_en_ro0[w]` and `iprf_wr_pkt_ro0[w]` are registered from the port packing.
- `iprf_wr_pkt_ro0[w]` loads only when the port is enabled; otherwise it holds its value.
- Two ports carrying the same pdst in one cycle is a producer bug. It is not resolved by this block and is flagged under `ASSERT`.

Reset (`reset_n` = 0 at an edge):
- `hold_valid` = 0, `hold_pkt` = 0, `rr_ptr` = 0, starve counters = 0.
- `iprf_wr_en_ro0` = 0, `iprf_wr_pkt_ro0` = 0.
- `req_ready` reads 1 for all r from the first cycle after reset.
- Reset mid-operation discards all held results. Requesters must not count them as written.

## Timing
- Accept at edge N (`req_valid` & `req_ready` in cycle N-1) → entry held in cycle N → `iprf_wr_en_ro0` asserted in cycle N+1 if granted in cycle N.
- Minimum latency is 2 cycles from `req_valid` to the port.
- Sustained throughput per requester is 1 result/cycle when not contended.
- Aggregate throughput is `IPRF_NUM_WRITES` results/cycle.
- Worst-case wait without starvation control is `ceil(NUM_REQ/IPRF_NUM_WRITES)` - 1 cycles of no grant.

## Configuration
- `IPRF_WR_ARB_STARVE_EN` defined:
  - Each requester has an 8-bit saturating wait counter.
  - The counter increments each cycle that `hold_valid[r]` is 1 and `grant[r]` is 0. It clears on grant or when `hold_valid[r]` is 0.
  - Requesters with counter ≥ `STARVE_LIMIT` are promoted: promoted candidates are scanned first, in `rr_ptr` order, then the rest in `rr_ptr` order.
  - Port packing follows this combined order.
- Undefined: no counters exist, and arbitration is pure round-robin as described above.

## Test plan
Test plan uses `IPRF_NUM_WRITES`=2 and `NUM_REQ`=4.
- Reset, then idle: all `iprf_wr_en_ro0` = 0 and all `req_ready` = 1 for 10 cycles.
- Single requester r=2 sends pdst=5 for 3 back-to-back cycles: port 0 shows pdst 5 on 3 consecutive cycles, starting 2 cycles after the first valid. `req_ready[2]` stays 1 throughout.
- All 4 requesters continuously valid from `rr_ptr`=0:
  - Cycle A grants r0 and r1 on ports 0 and 1; cycle B grants r2 and r3.
  - The pattern alternates, and `req_ready` toggles 1/0 per requester in the matching rhythm.
- Wrap-around: `rr_ptr`=3 with r3 and r0 valid grants r3 on port 0 and r0 on port 1; the next `rr_ptr` is 1.
- `reset_n` pulsed low while all 4 entries are held: the next cycle shows en = 0 on both ports, and the held packets never appear.
- `IPRF_WR_ARB_STARVE_EN` with `STARVE_LIMIT`=1:
  - Force r3 to lose one cycle, with r0–r2 valid and `rr_ptr`=0.
  - On the next cycle r3 occupies port 0, whatever `rr_ptr` is.
